// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 register file and exception-commit controller for the MEM stage.
// Arbitrates interrupts, exceptions and ERET, then issues a one-cycle flush plus PC redirect.
//
// state   | meaning
// S_IDLE  | accept MEM-stage instruction, evaluate take condition, service MTC0
// S_FLUSH | one-cycle flush/redirect pulse; instruction inputs ignored
module cp0_exc_unit #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instr_pc,
   input  logic        in_delay_slot,
   input  logic [4:0]  exc_code,
   input  logic        eret,
   input  logic        mtc0_we,
   input  logic [4:0]  cp0_waddr,
   input  logic [31:0] cp0_wdata,
   input  logic [4:0]  cp0_raddr,
   input  logic [5:0]  hw_int,
   output logic [31:0] cp0_rdata,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [31:0] epc_out,
   output logic [31:0] status_out,
   output logic [31:0] cause_out,
   output logic        timer_int
);

   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   state_t      state, state_nxt;
   logic [31:0] count_r, compare_r, status_r, epc_r, redirect_pc_r;
   logic        count_tog;
   logic        cause_bd, cause_ti;
   logic [7:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] cause_full;
   logic        int_req;
   logic        take_exc, take_eret, mtc0_go;
   logic [4:0]  exc_sel;
   logic        count_wr, compare_wr;

   assign cause_full = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};
   assign int_req    = status_r[0] & ~status_r[1] & (|(cause_ip & status_r[15:8]));
   assign count_wr   = mtc0_go && (cp0_waddr == 5'd9);
   assign compare_wr = mtc0_go && (cp0_waddr == 5'd11);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take_exc  = 1'b0;
      take_eret = 1'b0;
      mtc0_go   = 1'b0;
      exc_sel   = 5'd0;
      case (state)
         S_IDLE: begin
            if (instr_valid) begin
               if (int_req) begin
                  take_exc = 1'b1;
               end else if (exc_code != 5'd0) begin
                  take_exc = 1'b1;
                  exc_sel  = exc_code;
               end else if (eret) begin
                  take_eret = 1'b1;
               end else begin
                  mtc0_go = mtc0_we;
               end
            end
            if (take_exc || take_eret) state_nxt = S_FLUSH;
         end
         S_FLUSH: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_r       <= 32'd0;
         compare_r     <= 32'd0;
         status_r      <= STATUS_RST;
         epc_r         <= 32'd0;
         redirect_pc_r <= 32'd0;
         count_tog     <= 1'b0;
         cause_bd      <= 1'b0;
         cause_ti      <= 1'b0;
         cause_ip      <= 8'd0;
         cause_exc     <= 5'd0;
      end else begin
         cause_ip[7:2] <= {hw_int[5] | cause_ti, hw_int[4:0]};

         if (count_wr) begin
            count_r   <= cp0_wdata;
            count_tog <= 1'b0;
         end else begin
            count_tog <= ~count_tog;
            if (count_tog) count_r <= count_r + 32'd1;
         end

         // Compare write wins over a coincident match so software can always clear TI.
         if (compare_wr)
            cause_ti <= 1'b0;
         else if (!count_wr && count_tog && ((count_r + 32'd1) == compare_r))
            cause_ti <= 1'b1;

         if (mtc0_go) begin
            case (cp0_waddr)
               5'd11: compare_r     <= cp0_wdata;
               5'd12: status_r      <= (status_r & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
               5'd13: cause_ip[1:0] <= cp0_wdata[9:8];
               5'd14: epc_r         <= cp0_wdata;
               default: ;
            endcase
         end

         if (take_exc) begin
            if (!status_r[1]) begin
               epc_r    <= in_delay_slot ? instr_pc - 32'd4 : instr_pc;
               cause_bd <= in_delay_slot;
            end
            cause_exc     <= exc_sel;
            status_r[1]   <= 1'b1;
            redirect_pc_r <= EXC_VECTOR;
         end else if (take_eret) begin
            status_r[1]   <= 1'b0;
            redirect_pc_r <= epc_r;
         end
      end
   end

   always_comb begin
      cp0_rdata = 32'd0;
      case (cp0_raddr)
         5'd9:    cp0_rdata = count_r;
         5'd11:   cp0_rdata = compare_r;
         5'd12:   cp0_rdata = status_r;
         5'd13:   cp0_rdata = cause_full;
         5'd14:   cp0_rdata = epc_r;
         default: cp0_rdata = 32'd0;
      endcase
   end

   assign flush          = (state == S_FLUSH);
   assign redirect_valid = (state == S_FLUSH);
   assign redirect_pc    = redirect_pc_r;
   assign epc_out        = epc_r;
   assign status_out     = status_r;
   assign cause_out      = cause_full;
   assign timer_int      = cause_ti;

endmodule
